// File: rtl/rv_dec_pkg.sv
// Shared RISC-V decode types: load/store func3 encodings and the data-memory arbiter state.
package rv_dec;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_func3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_func3_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } dmem_arb_state_e;

endpackage

// File: rtl/ls_align_chk.sv
// Flags illegal func3 widths and misaligned halfword/word load/store addresses.
module ls_align_chk
  import rv_dec::*;
(
  input  logic       we,
  input  logic [2:0] func3,
  input  logic [1:0] addr,
  output logic       bad
);

  always_comb begin
    bad = 1'b0;
    if (we) begin
      case (store_func3_e'(func3))
        SB:      bad = 1'b0;
        SH:      bad = addr[0];
        SW:      bad = |addr;
        default: bad = 1'b1;
      endcase
    end else begin
      case (load_func3_e'(func3))
        LB, LBU: bad = 1'b0;
        LH, LHU: bad = addr[0];
        LW:      bad = |addr;
        default: bad = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// Two-port arbiter/sequencer for the data memory: grant, one-cycle access, registered response.
module dmem_arb
  import rv_dec::*;
#(
  parameter int unsigned AW         = 11,
  parameter int unsigned DW         = 32,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [1:0][AW-1:0]  addr,
  input  logic [1:0][DW-1:0]  wdata,
  input  logic [1:0][2:0]     func3,
  output logic [1:0]          gnt,
  output logic [1:0]          rvalid,
  output logic [DW-1:0]       rdata,
  output logic                err,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic [2:0]          mem_func3,
  output logic                mem_rd_en,
  output logic                mem_wr_en,
  input  logic [DW-1:0]       mem_rdata
);

  dmem_arb_state_e state_q, state_d;

  logic          last_q;  // 1 = port 1 was granted last
  logic          id_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [2:0]    func3_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          bad;
  logic          accept;
  logic          in_access;

  ls_align_chk u_align_chk (
    .we    (we_q),
    .func3 (func3_q),
    .addr  (addr_q[1:0]),
    .bad   (bad)
  );

  always_comb begin
    state_d = state_q;
    gnt     = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ACCESS;
          if (req == 2'b11) begin
            gnt = (FIXED_PRIO || last_q) ? 2'b01 : 2'b10;
          end else begin
            gnt = req;
          end
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept    = |gnt;
  assign in_access = (state_q == ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q  <= gnt[1];
        id_q    <= gnt[1];
        we_q    <= we[gnt[1]];
        addr_q  <= addr[gnt[1]];
        wdata_q <= wdata[gnt[1]];
        func3_q <= func3[gnt[1]];
      end
      if (in_access) begin
        rdata_q <= (!we_q && !bad) ? mem_rdata : '0;
        err_q   <= bad;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_func3 = func3_q;
  assign mem_rd_en = in_access && !we_q && !bad;
  assign mem_wr_en = in_access && we_q && !bad;

  assign rvalid = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule

// File: doc/dmem_arb.md
Name: dmem_arb

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed data memory (11-bit address, func3-encoded load/store width, combinational read, negedge write).
- Port 0 is the core load/store path. Port 1 is the loader/debug path used to preload or inspect data memory.
- Picks one request at a time and drives the memory control signals for exactly one cycle.
- Returns a registered response. Misaligned or illegal-width accesses are trapped before they reach memory.

Parameters:
- AW, 11, memory byte-address width
- DW, 32, data width
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-port request; bit i = port i
- we  in  2  per-port write enable; 1 = store, 0 = load
- addr  in  2xAW  per-port byte address
- wdata  in  2xDW  per-port store data
- func3  in  2x3  per-port RISC-V func3 (LB/LH/LW/LBU/LHU or SB/SH/SW)
- gnt  out  2  combinational grant; the request is accepted at the rising edge where gnt[i] is high
- rvalid  out  2  one-cycle response strobe to port i
- rdata  out  DW  load result, valid with rvalid
- err  out  1  access trapped, valid with rvalid
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory store data
- mem_func3  out  3  memory width select
- mem_rd_en  out  1  memory read enable
- mem_wr_en  out  1  memory write enable
- mem_rdata  in  DW  memory read data

Behaviour:
- States:
  - IDLE: accepts a request.
  - ACCESS: drives memory for one cycle.
  - RESP: asserts the response.
- Transitions: IDLE -> ACCESS when any req is high; otherwise stay in IDLE. ACCESS -> RESP always. RESP -> IDLE always.
- Grant:
  - gnt is nonzero only in IDLE and is one-hot.
  - Only port 0 requesting -> gnt=01. Only port 1 requesting -> gnt=10.
  - Both requesting: with FIXED_PRIO=1, port 0 wins. With FIXED_PRIO=0, the port not granted last wins.
  - The last-grant register resets to 1, so port 0 wins the first tie.
- Capture: at the accepting edge, latch port id, we, addr, wdata and func3. The requester may drop or change its inputs afterwards.
- Alignment/legality check on the latched request:
  - Load func3 must be 0, 1, 2, 4 or 5. Store func3 must be 0, 1 or 2.
  - Halfword accesses require addr[0]=0. Word accesses require addr[1:0]=00.
  - Any violation sets the internal bad flag.
- ACCESS:
  - mem_addr, mem_wdata and mem_func3 come from the latched values.
  - mem_rd_en = !we & !bad; mem_wr_en = we & !bad.
  - Memory commits a store on the negedge inside this cycle.
  - For loads, mem_rdata is registered at the end of ACCESS.
- RESP:
  - rvalid[id]=1 for exactly one cycle.
  - rdata = captured load data; it is 0 for stores and for trapped accesses.
  - err = bad.
- Memory interface:
  - Outside ACCESS, mem_rd_en=mem_wr_en=0.
  - mem_addr, mem_wdata and mem_func3 hold their last values; they are 0 after reset.
- Latency: accept edge T -> memory access in cycle T+1 -> rvalid in cycle T+2.
- Throughput: one transaction per 3 cycles. The earliest next gnt is in the cycle after RESP.
- Legal accesses never cross address 2047, because alignment guarantees it; no wrap handling is needed.
- Reset values: state=IDLE, gnt=0, rvalid=0, rdata=0, err=0, all mem_* outputs 0, last-grant=1.
- Reset mid-operation:
  - Asynchronous reset immediately drops mem_wr_en and mem_rd_en.
  - A store whose ACCESS cycle is cut before its negedge does not commit.
  - No rvalid is issued for an aborted transaction.
- A request arriving during ACCESS or RESP is not granted. It must be held until gnt.

Decomposition:
- Shared package (rv_dec):
  - Add enum dmem_arb_state_e {IDLE, ACCESS, RESP}.
  - Reuse the existing load and store func3 enums for the legality check. No new func3 constants.
- Sub-module ls_align_chk (combinational): inputs we, func3, addr[1:0]; output bad.
- The arbiter/FSM stays in dmem_arb.

Test Plan:
1. Port 0 store SW addr=0x010 wdata=0xDEADBEEF, then a load LW addr=0x010 -> gnt[0] at accept; mem_wr_en high for one cycle; store rvalid[0] with rdata=0, err=0; load rvalid[0] two cycles after its accept with rdata=0xDEADBEEF.
2. Port 1 loads after stores to the same word: LB addr=0x011 after SB 0x80 -> rdata=0xFFFFFF80; LBU -> 0x00000080; LH addr=0x012 after SH 0x8001 -> 0xFFFF8001.
3. Both ports request continuously, FIXED_PRIO=0 -> grants alternate port 0, 1, 0, 1, each 3 cycles apart. With FIXED_PRIO=1 -> port 0 only, port 1 is starved.
4. Misaligned LW addr=0x013, SH addr=0x021, and load func3=3 -> mem_rd_en and mem_wr_en stay 0; rvalid with err=1, rdata=0; memory contents unchanged.
5. Assert rst_n low during ACCESS of SW addr=0x040 wdata=0x12345678, before the negedge -> memory word at 0x040 unchanged; no rvalid; all outputs 0; first grant after release goes to port 0 on a tie.
6. Port 0 drops req in the cycle after gnt, and its addr changes to 0x7FC -> the access still uses the latched address; the response goes to port 0 only.
